// File: rtl/bits_pack_if.sv
// Field-in / word-out bus of the bits_pack packer.
// The producer of fields is the master; the packer is the slave.
interface bits_pack_if;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flushin;
  logic        readyout;
  logic        pushout;
  logic [31:0] dataout;
  logic [5:0]  validbits;

  modport master (
    output pushin, lenin, datain, flushin,
    input  readyout, pushout, dataout, validbits
  );

  modport slave (
    input  pushin, lenin, datain, flushin,
    output readyout, pushout, dataout, validbits
  );
endinterface

// File: rtl/bits_pack.sv
// Variable-length bit packer: 0-15 bit fields are concatenated LSB-first into
// 32-bit words; a flush drains the partial word zero-padded.
module bits_pack (
  input  logic        clk,
  input  logic        rst_n,
  bits_pack_if.slave  bus
);

  typedef enum logic [0:0] {RUN = 1'b0, TAIL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [46:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        pushout_q, pushout_d;
  logic [31:0] dataout_q, dataout_d;
  logic [5:0]  validbits_q, validbits_d;
  logic        readyout_q, readyout_d;

  logic [3:0]  len_s;
  logic [14:0] mask_s;
  logic [46:0] merged_s;
  logic [5:0]  n_s;

  // Merge an accepted field into the accumulator above the pending bits.
  always_comb begin
    if (bus.pushin && (state_q == RUN)) begin
      len_s = bus.lenin;
    end else begin
      len_s = 4'd0;
    end
    mask_s   = 15'((16'd1 << len_s) - 16'd1);
    merged_s = acc_q | ({32'd0, bus.datain & mask_s} << cnt_q);
    n_s      = cnt_q + {2'b00, len_s};
  end

  // Next-state, word emission and readiness.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pushout_d   = 1'b0;
    dataout_d   = dataout_q;
    validbits_d = validbits_q;
    case (state_q)
      RUN: begin
        if (bus.flushin) begin
          if (n_s == 6'd0) begin
            acc_d = 47'd0;
            cnt_d = 6'd0;
          end else if (n_s <= 6'd32) begin
            // Bits above n are already zero, so the word is padded for free.
            pushout_d   = 1'b1;
            dataout_d   = merged_s[31:0];
            validbits_d = n_s;
            acc_d       = 47'd0;
            cnt_d       = 6'd0;
          end else begin
            pushout_d   = 1'b1;
            dataout_d   = merged_s[31:0];
            validbits_d = 6'd32;
            acc_d       = merged_s >> 32;
            cnt_d       = n_s - 6'd32;
            state_d     = TAIL;
          end
        end else if (n_s >= 6'd32) begin
          pushout_d   = 1'b1;
          dataout_d   = merged_s[31:0];
          validbits_d = 6'd32;
          acc_d       = merged_s >> 32;
          cnt_d       = n_s - 6'd32;
        end else begin
          acc_d = merged_s;
          cnt_d = n_s;
        end
      end
      TAIL: begin
        pushout_d   = 1'b1;
        dataout_d   = acc_q[31:0];
        validbits_d = cnt_q;
        acc_d       = 47'd0;
        cnt_d       = 6'd0;
        state_d     = RUN;
      end
      default: begin
        acc_d   = 47'd0;
        cnt_d   = 6'd0;
        state_d = RUN;
      end
    endcase
    readyout_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      acc_q       <= 47'd0;
      cnt_q       <= 6'd0;
      pushout_q   <= 1'b0;
      dataout_q   <= 32'd0;
      validbits_q <= 6'd0;
      readyout_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pushout_q   <= pushout_d;
      dataout_q   <= dataout_d;
      validbits_q <= validbits_d;
      readyout_q  <= readyout_d;
    end
  end

  assign bus.pushout   = pushout_q;
  assign bus.dataout   = dataout_q;
  assign bus.validbits = validbits_q;
  assign bus.readyout  = readyout_q;

endmodule

// File: tb/tb_bits_pack.sv
// Self-checking bench for bits_pack: directed scenarios plus random traffic,
// compared against a bit-queue reference model.
module tb_bits_pack;

  logic clk;
  logic rst_n;
  bits_pack_if bif ();

  bits_pack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending bits in arrival order plus expected outputs.
  bit          q[$];
  bit          m_rdy;
  logic        e_po;
  logic [31:0] e_do;
  logic [5:0]  e_vb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy = 1'b1;
    e_po  = 1'b0;
    e_do  = 32'd0;
    e_vb  = 6'd0;
  endtask

  task automatic emit();
    int k;
    logic [31:0] w;
    w = 32'd0;
    k = (q.size() > 32) ? 32 : q.size();
    for (int i = 0; i < k; i++) w[i] = q.pop_front();
    e_po = 1'b1;
    e_do = w;
    e_vb = 6'(k);
  endtask

  task automatic model_step(input logic p, input logic [3:0] l, input logic [14:0] d, input logic f);
    e_po = 1'b0;
    if (!m_rdy) begin
      emit();
      m_rdy = 1'b1;
    end else begin
      if (p) for (int i = 0; i < int'(l); i++) q.push_back(d[i]);
      if (f) begin
        if (q.size() > 32) begin
          emit();
          m_rdy = 1'b0;
        end else if (q.size() > 0) begin
          emit();
        end
      end else if (q.size() >= 32) begin
        emit();
      end
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, check against the model.
  task automatic step(input string tag, input logic p, input logic [3:0] l,
                      input logic [14:0] d, input logic f);
    bif.pushin  = p;
    bif.lenin   = l;
    bif.datain  = d;
    bif.flushin = f;
    @(posedge clk);
    #1;
    model_step(p, l, d, f);
    chk({tag, ".pushout"},   32'(bif.pushout),   32'(e_po));
    chk({tag, ".dataout"},   bif.dataout,        e_do);
    chk({tag, ".validbits"}, 32'(bif.validbits), 32'(e_vb));
    chk({tag, ".readyout"},  32'(bif.readyout),  32'(m_rdy));
  endtask

  initial begin
    rst_n       = 1'b0;
    bif.pushin  = 1'b0;
    bif.lenin   = 4'd0;
    bif.datain  = 15'd0;
    bif.flushin = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pushout",   32'(bif.pushout),   32'd0);
    chk("reset.dataout",   bif.dataout,        32'd0);
    chk("reset.validbits", 32'(bif.validbits), 32'd0);
    chk("reset.readyout",  32'(bif.readyout),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-bit packing, alternating 1,0,...
    for (int i = 0; i < 32; i++) step("t1", 1'b1, 4'd1, 15'((i % 2 == 0) ? 1 : 0), 1'b0);
    chk("t1.word", bif.dataout, 32'h5555_5555);
    step("t1idle", 1'b0, 4'd0, 15'd0, 1'b0);

    // Straddling 15-bit fields, then flush of the 13 leftover ones.
    step("t2a", 1'b1, 4'd15, 15'h7FFF, 1'b0);
    step("t2b", 1'b1, 4'd15, 15'h0000, 1'b0);
    step("t2c", 1'b1, 4'd15, 15'h7FFF, 1'b0);
    chk("t2.word", bif.dataout, 32'hC000_7FFF);
    step("t4a", 1'b0, 4'd0, 15'd0, 1'b1);
    chk("t4.word", bif.dataout, 32'h0000_1FFF);
    chk("t4.vb", 32'(bif.validbits), 32'd13);
    step("t4b", 1'b0, 4'd0, 15'd0, 1'b1);

    // Zero length and masking.
    step("t3a", 1'b1, 4'd0, 15'h7FFF, 1'b0);
    step("t3b", 1'b1, 4'd4, 15'h7FF5, 1'b0);
    step("t3c", 1'b0, 4'd0, 15'd0, 1'b1);
    chk("t3.word", bif.dataout, 32'h0000_0005);
    chk("t3.vb", 32'(bif.validbits), 32'd4);

    // Flush overflow from 30 pending zeros, with a dropped push during the tail.
    step("t5a", 1'b1, 4'd15, 15'h0000, 1'b0);
    step("t5b", 1'b1, 4'd15, 15'h0000, 1'b0);
    step("t5c", 1'b1, 4'd4, 15'h000F, 1'b1);
    chk("t5.word1", bif.dataout, 32'hC000_0000);
    chk("t5.rdy_low", 32'(bif.readyout), 32'd0);
    step("t5d", 1'b1, 4'd15, 15'h7FFF, 1'b1);
    chk("t5.word2", bif.dataout, 32'h0000_0003);
    chk("t5.vb2", 32'(bif.validbits), 32'd2);
    chk("t5.rdy_high", 32'(bif.readyout), 32'd1);
    step("t5e", 1'b0, 4'd0, 15'd0, 1'b0);

    // Reset between edges with 20 bits pending.
    step("t6a", 1'b1, 4'd10, 15'h03FF, 1'b0);
    step("t6b", 1'b1, 4'd10, 15'h0155, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst_pushout",   32'(bif.pushout),   32'd0);
    chk("t6.rst_dataout",   bif.dataout,        32'd0);
    chk("t6.rst_validbits", 32'(bif.validbits), 32'd0);
    chk("t6.rst_readyout",  32'(bif.readyout),  32'd1);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 32; i++) step("t6", 1'b1, 4'd1, 15'd1, 1'b0);
    chk("t6.word", bif.dataout, 32'hFFFF_FFFF);

    // Random traffic, including pushes and flushes during the tail cycle.
    for (int i = 0; i < 600; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           15'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    // Sustained full-rate 15-bit pushes.
    for (int i = 0; i < 40; i++) step("full", 1'b1, 4'd15, 15'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bits_pack.md
# bits_pack

Variable-length bit packer: the write-side counterpart of the `bits` unpacker. Accepts fields of 0–15 bits per cycle and concatenates them LSB-first into 32-bit words. Each completed word is emitted with a one-cycle registered latency. A flush request drains a partial word zero-padded, so a bitstream built here can be read back field-for-field by `bits`.

## Interface
- No parameters; widths fixed (field ≤15 bits, word 32 bits).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `pushin` in 1: field valid this cycle.
- `lenin` in 4: field length in bits, 0–15.
- `datain` in 15: field value; bits at index ≥ `lenin` are ignored (masked).
- `flushin` in 1: emit all pending bits as a zero-padded word.
- `readyout` out 1: high when `pushin`/`flushin` are accepted.
- `pushout` out 1: `dataout` valid this cycle, one-cycle pulse.
- `dataout` out 32: packed word, first-pushed bit at bit 0.
- `validbits` out 6: number of valid bits in `dataout`, 1–32 (32 for full words).

## Operation
- **State:**
  - 47-bit accumulator `acc`.
  - 6-bit count `cnt` (0–31 between cycles).
  - FSM with states RUN and TAIL.
- **Push in RUN** (`pushin` && `readyout`):
  - Masked `datain` is placed at `acc[cnt +: lenin]`.
  - n = cnt + lenin, range 0–46.
- **No flush:**
  - n ≥ 32: emit `acc[31:0]` with validbits=32, then shift `acc` right by 32 and set cnt = n−32.
  - Otherwise cnt = n and nothing is emitted.
  - At most one word per cycle, so no input stall is needed.
- **`flushin` in RUN** (with or without a push):
  - n = 0: no output.
  - 1 ≤ n ≤ 32: emit `acc[31:0]` zero-padded above bit n−1, with validbits=n; cnt=0.
  - n > 32: emit the full word (validbits=32), keep n−32 bits, go to TAIL.
- **TAIL:**
  - `readyout`=0.
  - Emit the remaining bits zero-padded with validbits=cnt, set cnt=0, return to RUN.
  - `pushin`/`flushin` are ignored (dropped) while `readyout`=0.
- `lenin`=0 with `pushin` has no effect on `acc`/`cnt`.
- Unused `acc` bits above `cnt` are always held at zero, so padding is zero with no extra masking.

## Timing
- **Reset values:**
  - `pushout`=0, `dataout`=0, `validbits`=0, `readyout`=1.
  - cnt=0, `acc`=0, FSM=RUN.
- Reset clears everything asynchronously on `rst_n` falling, including mid-word and in TAIL; pending bits are discarded.
- **Latency:**
  - A word completed by the input at edge k appears on `pushout`/`dataout`/`validbits` after edge k+1 and holds for exactly one cycle.
  - `dataout`/`validbits` hold their last value when `pushout`=0.
- `readyout` is registered. It drops in the cycle following a flush with n > 32 and returns high one cycle later.
- Back-to-back pushes of 15 bits sustain full throughput indefinitely; `pushout` is high at most every other cycle.

## Test plan
1. **Single-bit packing.** 32 pushes of lenin=1, datain alternating 1,0,1,0… → one cycle after the 32nd push: pushout=1, dataout=0x55555555, validbits=32; no earlier pushout.
2. **Straddling fields.** Pushes of len 15 with data 0x7FFF, then 0x0000, then 0x7FFF → after the third push: dataout=0xC0007FFF, validbits=32; internal cnt=13 holding 13 ones.
3. **Zero length and masking.** Push lenin=0 with datain=0x7FFF → no change. Then push lenin=4, datain=0x7FF5, then flush → dataout=0x00000005, validbits=4.
4. **Flush paths.** With cnt=13 (all ones), assert flushin → dataout=0x00001FFF, validbits=13. A second flush with cnt=0 → no pushout.
5. **Flush overflow.** With cnt=30 (zeros), push len 4 data 0xF together with flushin:
   - Word 1: dataout=0xC0000000, validbits=32.
   - Next cycle readyout=0; a push issued then is dropped.
   - Word 2: dataout=0x00000003, validbits=2.
   - readyout returns to 1.
6. **Reset mid-operation.** With cnt=20, pulse rst_n low between clock edges → outputs go to 0 and readyout to 1 immediately. After release, 32 pushes of len 1, data 1 → dataout=0xFFFFFFFF with no stale bits.
